// File: rtl/zap_multiply_sequencer_pkg.sv
// Shared types and constants for the multiply issue/retire sequencer.
package zap_multiply_sequencer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StDrain,
      StDone
   } mul_state_e;

   // Bit positions within a {N,Z,C,V} flag nibble
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/zap_multiply_sequencer_flag_gen.sv
// Combinational N/Z generation from a 32-bit result; C and V pass straight through.
module zap_multiply_sequencer_flag_gen
   import zap_multiply_sequencer_pkg::*;
(
   input  logic [31:0] result,
   input  logic        c_in,
   input  logic        v_in,
   output logic [3:0]  nzcv
);

   always_comb begin
      nzcv         = '0;
      nzcv[FLAG_N] = result[31];
      nzcv[FLAG_Z] = (result == 32'd0);
      nzcv[FLAG_C] = c_in;
      nzcv[FLAG_V] = v_in;
   end

endmodule

// File: rtl/zap_multiply_sequencer.sv
// Issue/retire sequencer wrapped around the 4-stage MAC: holds operands, pulses start,
// captures the MAC result with fresh N/Z flags and presents it to writeback.
module zap_multiply_sequencer
   import zap_multiply_sequencer_pkg::*;
#(
   parameter int unsigned DEST_W = 6
)
(
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_clear,
   input  logic              i_valid,
   input  logic              i_accumulate,
   input  logic              i_set_flags,
   input  logic [31:0]       i_rm,
   input  logic [31:0]       i_rs,
   input  logic [31:0]       i_rn,
   input  logic [DEST_W-1:0] i_dest,
   input  logic [3:0]        i_cpsr_nzcv,
   output logic              o_stall,
   output logic              o_mul_start,
   output logic              o_mul_clear,
   output logic [31:0]       o_mul_rm,
   output logic [31:0]       o_mul_rs,
   output logic [31:0]       o_mul_rn,
   input  logic [31:0]       i_mul_rd,
   input  logic              i_mul_busy,
   input  logic              i_stall,
   output logic              o_valid,
   output logic [31:0]       o_result,
   output logic [DEST_W-1:0] o_dest,
   output logic [3:0]        o_nzcv,
   output logic              o_nzcv_we
);

   mul_state_e        state_q, state_d;
   logic              accept, capture;
   logic [31:0]       rm_q, rs_q, rn_q, result_q;
   logic [DEST_W-1:0] dest_q;
   logic              s_q, c_q, v_q;
   logic [3:0]        nzcv_q, flags_new;
   logic              unused_nz;

   // Only C and V of the incoming flags survive a multiply
   assign unused_nz = ^i_cpsr_nzcv[FLAG_N:FLAG_Z];

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      capture     = 1'b0;
      o_mul_start = 1'b0;
      o_valid     = 1'b0;
      case (state_q)
         StIdle: begin
            if (i_valid && !i_clear) begin
               accept  = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            o_mul_start = !i_clear;
            state_d     = i_clear ? StIdle : StWait;
         end
         StWait: begin
            // A flush wins over a result arriving in the same cycle
            if (i_clear) begin
               state_d = StDrain;
            end else if (!i_mul_busy) begin
               capture = 1'b1;
               state_d = StDone;
            end
         end
         StDrain: begin
            if (!i_mul_busy) state_d = StIdle;
         end
         StDone: begin
            o_valid = !i_clear;
            if (!i_stall || i_clear) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   zap_multiply_sequencer_flag_gen u_flag_gen (
      .result (i_mul_rd),
      .c_in   (c_q),
      .v_in   (v_q),
      .nzcv   (flags_new)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= StIdle;
         rm_q     <= '0;
         rs_q     <= '0;
         rn_q     <= '0;
         dest_q   <= '0;
         s_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         result_q <= '0;
         nzcv_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rm_q   <= i_rm;
            rs_q   <= i_rs;
            rn_q   <= i_accumulate ? i_rn : 32'd0;
            dest_q <= i_dest;
            s_q    <= i_set_flags;
            c_q    <= i_cpsr_nzcv[FLAG_C];
            v_q    <= i_cpsr_nzcv[FLAG_V];
         end
         if (capture) begin
            result_q <= i_mul_rd;
            nzcv_q   <= flags_new;
         end
      end
   end

   assign o_stall     = (state_q != StIdle);
   assign o_mul_clear = i_clear;
   assign o_mul_rm    = rm_q;
   assign o_mul_rs    = rs_q;
   assign o_mul_rn    = rn_q;
   assign o_result    = result_q;
   assign o_dest      = dest_q;
   assign o_nzcv      = nzcv_q;
   assign o_nzcv_we   = o_valid & s_q;

endmodule

// File: tb/tb_zap_multiply_sequencer.sv
// Self-checking bench for zap_multiply_sequencer with a behavioural 4-stage MAC beneath it.
module tb_zap_multiply_sequencer;

   typedef struct {
      logic [31:0] rm, rs, rn;
      logic        acc, s;
      logic [3:0]  nzcv;
      logic [5:0]  dest;
      int          stall;
      logic [31:0] exp_result;
      logic [3:0]  exp_nzcv;
      logic        exp_we;
   } vec_t;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_clear = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_accumulate = 1'b0;
   logic        i_set_flags = 1'b0;
   logic [31:0] i_rm = '0, i_rs = '0, i_rn = '0;
   logic [5:0]  i_dest = '0;
   logic [3:0]  i_cpsr_nzcv = '0;
   logic        i_stall = 1'b0;
   logic        o_stall, o_mul_start, o_mul_clear, o_valid, o_nzcv_we;
   logic [31:0] o_mul_rm, o_mul_rs, o_mul_rn, o_result;
   logic [5:0]  o_dest;
   logic [3:0]  o_nzcv;
   logic [31:0] mul_rd;
   logic        mul_busy;

   int n_vec = 0;
   int n_miss = 0;

   always #5 i_clk = ~i_clk;

   zap_multiply_sequencer #(.DEST_W(6)) dut (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_clear      (i_clear),
      .i_valid      (i_valid),
      .i_accumulate (i_accumulate),
      .i_set_flags  (i_set_flags),
      .i_rm         (i_rm),
      .i_rs         (i_rs),
      .i_rn         (i_rn),
      .i_dest       (i_dest),
      .i_cpsr_nzcv  (i_cpsr_nzcv),
      .o_stall      (o_stall),
      .o_mul_start  (o_mul_start),
      .o_mul_clear  (o_mul_clear),
      .o_mul_rm     (o_mul_rm),
      .o_mul_rs     (o_mul_rs),
      .o_mul_rn     (o_mul_rn),
      .i_mul_rd     (mul_rd),
      .i_mul_busy   (mul_busy),
      .i_stall      (i_stall),
      .o_valid      (o_valid),
      .o_result     (o_result),
      .o_dest       (o_dest),
      .o_nzcv       (o_nzcv),
      .o_nzcv_we    (o_nzcv_we)
   );

   // MAC stand-in: busy in the start cycle plus four more, result ready when busy falls.
   // It ignores clear, as the real unit cannot abort.
   logic [2:0]  mac_cnt;
   logic [31:0] mac_res;
   assign mul_busy = o_mul_start | (mac_cnt != 3'd0);
   assign mul_rd   = mac_res;
   always @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         mac_cnt <= 3'd0;
         mac_res <= 32'd0;
      end else if (o_mul_start) begin
         mac_cnt <= 3'd4;
         mac_res <= o_mul_rm * o_mul_rs + o_mul_rn;
      end else if (mac_cnt != 3'd0) begin
         mac_cnt <= mac_cnt - 3'd1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   function automatic vec_t make_vec(input logic [31:0] rm, input logic [31:0] rs,
                                     input logic [31:0] rn, input logic acc, input logic s,
                                     input logic [3:0] nzcv, input logic [5:0] dest,
                                     input int stall);
      vec_t        v;
      logic [63:0] full;
      full = 64'(rm) * 64'(rs) + (acc ? 64'(rn) : 64'd0);
      v.rm = rm; v.rs = rs; v.rn = rn; v.acc = acc; v.s = s;
      v.nzcv = nzcv; v.dest = dest; v.stall = stall;
      v.exp_result = full[31:0];
      v.exp_nzcv   = {full[31], (full[31:0] == 32'd0), nzcv[1], nzcv[0]};
      v.exp_we     = s;
      return v;
   endfunction

   task automatic drive_op(input vec_t v);
      i_rm = v.rm; i_rs = v.rs; i_rn = v.rn;
      i_accumulate = v.acc; i_set_flags = v.s;
      i_cpsr_nzcv = v.nzcv; i_dest = v.dest;
   endtask

   task automatic scramble();
      i_rm = $urandom; i_rs = $urandom; i_rn = $urandom;
      i_accumulate = 1'($urandom); i_set_flags = 1'($urandom);
      i_cpsr_nzcv = 4'($urandom); i_dest = 6'($urandom);
   endtask

   task automatic accept(input vec_t v);
      drive_op(v);
      i_valid = 1'b1;
      #1;
      chk("accept_idle", 32'(o_stall), 32'd0);
      step();
      i_valid = 1'b0;
      scramble();
   endtask

   // Full op: accept at cycle 0, o_valid from cycle 7 until writeback stall releases
   task automatic run_op(input vec_t v, input bit hold_valid);
      int last;
      last = 7 + v.stall;
      accept(v);
      i_valid = hold_valid;
      for (int c = 1; c <= last; c++) begin
         i_stall = (c < last);
         #1;
         chk("stall_busy", 32'(o_stall), 32'd1);
         chk("mul_start", 32'(o_mul_start), 32'(c == 1));
         chk("valid_timing", 32'(o_valid), 32'(c >= 7));
         if (c == 1) begin
            chk("mul_rm", o_mul_rm, v.rm);
            chk("mul_rs", o_mul_rs, v.rs);
            chk("mul_rn", o_mul_rn, v.acc ? v.rn : 32'd0);
         end
         if (c >= 7) begin
            chk("result", o_result, v.exp_result);
            chk("nzcv", 32'(o_nzcv), 32'(v.exp_nzcv));
            chk("nzcv_we", 32'(o_nzcv_we), 32'(v.exp_we));
            chk("dest", 32'(o_dest), 32'(v.dest));
         end
         step();
      end
      i_stall = 1'b0;
      i_valid = 1'b0;
      #1;
      chk("back_idle", 32'(o_stall), 32'd0);
   endtask

   vec_t table_v[4];
   vec_t v;
   int   n;

   initial begin
      table_v[0] = '{rm: 32'd3, rs: 32'd5, rn: 32'd7, acc: 1'b1, s: 1'b1, nzcv: 4'b0011,
                     dest: 6'd5, stall: 0, exp_result: 32'd22, exp_nzcv: 4'b0011, exp_we: 1'b1};
      table_v[1] = '{rm: 32'd0, rs: 32'h1234, rn: 32'h55, acc: 1'b0, s: 1'b1, nzcv: 4'b1010,
                     dest: 6'd9, stall: 0, exp_result: 32'd0, exp_nzcv: 4'b0110, exp_we: 1'b1};
      table_v[2] = '{rm: 32'd1, rs: 32'd0, rn: 32'h8000_0000, acc: 1'b1, s: 1'b0, nzcv: 4'b0000,
                     dest: 6'd63, stall: 1, exp_result: 32'h8000_0000, exp_nzcv: 4'b1000,
                     exp_we: 1'b0};
      table_v[3] = '{rm: 32'hFFFF_FFFF, rs: 32'd2, rn: 32'd2, acc: 1'b1, s: 1'b1, nzcv: 4'b0100,
                     dest: 6'd1, stall: 0, exp_result: 32'd0, exp_nzcv: 4'b0100, exp_we: 1'b1};

      // Reset state
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_stall", 32'(o_stall), 32'd0);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_start", 32'(o_mul_start), 32'd0);
      chk("rst_we", 32'(o_nzcv_we), 32'd0);
      chk("rst_result", o_result, 32'd0);
      chk("rst_nzcv", 32'(o_nzcv), 32'd0);
      #3 i_reset_n = 1'b1;
      step();

      for (int i = 0; i < 4; i++) run_op(table_v[i], 1'b0);

      // Writeback stall for three DONE cycles while a second op is waiting
      v = make_vec(32'd11, 32'd13, 32'd100, 1'b1, 1'b1, 4'b0001, 6'd7, 3);
      run_op(v, 1'b1);
      step();
      chk("no_accept_in_done", 32'(o_stall), 32'd0);

      // Flush in ISSUE: no start pulse, straight back to idle
      v = make_vec(32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 4'b0000, 6'd2, 0);
      accept(v);
      i_clear = 1'b1;
      #1;
      chk("issue_clr_start", 32'(o_mul_start), 32'd0);
      chk("issue_clr_mclear", 32'(o_mul_clear), 32'd1);
      step();
      i_clear = 1'b0;
      #1;
      chk("issue_clr_idle", 32'(o_stall), 32'd0);

      // Flush in WAIT (cycle 3): drain until MAC busy drops, never present a result
      v = make_vec(32'd9, 32'd9, 32'd1, 1'b1, 1'b1, 4'b0000, 6'd3, 0);
      accept(v);
      step();
      step();
      i_clear = 1'b1;
      #1;
      chk("wait_clr_valid", 32'(o_valid), 32'd0);
      step();
      i_clear = 1'b0;
      n = 4;
      while (o_stall === 1'b1 && n < 30) begin
         chk("drain_no_valid", 32'(o_valid), 32'd0);
         step();
         n++;
      end
      chk("drain_exit_cycle", 32'(n), 32'd7);
      run_op(make_vec(32'd123, 32'd456, 32'd789, 1'b1, 1'b1, 4'b0010, 6'd4, 0), 1'b0);

      // Flush in DONE suppresses o_valid and the flag write
      v = make_vec(32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 4'b0000, 6'd8, 0);
      accept(v);
      for (int c = 1; c < 7; c++) step();
      chk("done_valid_pre", 32'(o_valid), 32'd1);
      i_clear = 1'b1;
      #1;
      chk("done_clr_valid", 32'(o_valid), 32'd0);
      chk("done_clr_we", 32'(o_nzcv_we), 32'd0);
      step();
      i_clear = 1'b0;
      #1;
      chk("done_clr_idle", 32'(o_stall), 32'd0);

      // Asynchronous reset mid-op (cycle 4)
      v = make_vec(32'd77, 32'd3, 32'd9, 1'b1, 1'b1, 4'b0011, 6'd12, 0);
      accept(v);
      for (int c = 1; c < 4; c++) step();
      #2 i_reset_n = 1'b0;
      #1;
      chk("arst_stall", 32'(o_stall), 32'd0);
      chk("arst_valid", 32'(o_valid), 32'd0);
      chk("arst_start", 32'(o_mul_start), 32'd0);
      chk("arst_we", 32'(o_nzcv_we), 32'd0);
      chk("arst_mul_rm", o_mul_rm, 32'd0);
      chk("arst_result", o_result, 32'd0);
      chk("arst_dest", 32'(o_dest), 32'd0);
      @(posedge i_clk);
      #2 i_reset_n = 1'b1;
      step();
      run_op(make_vec(32'd2, 32'd2, 32'd0, 1'b0, 1'b1, 4'b0000, 6'd10, 0), 1'b0);

      // Randomised ops against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         logic [31:0] rm;
         rm = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         v = make_vec(rm, $urandom, $urandom, 1'($urandom), 1'($urandom), 4'($urandom),
                      6'($urandom), int'($urandom_range(0, 2)));
         run_op(v, 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
